vga_scanout: RTL

//  Read side of videoMem: generates 640x480@60 VGA timing, reads the 9-bit frame buffer linearly
//  (addr = y*640 + x, the same layout the image/font placer writes) and drives sync, blank and
//  RGB888 to the DAC. Sits between the videoMem read port and the board VGA pins.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen.sv | 65 ++++++
 rtl/vga_scanout.sv | 103 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer pixel type and colour expansion.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_WORDS = 307200;

  localparam int unsigned HC_W   = 10;
  localparam int unsigned VC_W   = 10;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 9;
  localparam int unsigned CH_W   = 8;

  // Frame-buffer word: {R[2:0], G[2:0], B[2:0]}
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pix9_t;

  // Stretch a 3-bit channel to 8 bits by bit replication (000->00, 111->FF)
  function automatic logic [CH_W-1:0] expand3to8(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider plus horizontal/vertical counters and the raw timing decodes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned V_ACTIVE_LINES = V_ACTIVE,
  parameter int unsigned V_FP_LINES     = V_FP,
  parameter int unsigned V_SYNC_LINES   = V_SYNC,
  parameter int unsigned V_BP_LINES     = V_BP
) (
  input  logic            clk,
  input  logic            rst,
  output logic            pix_en_c,
  output logic [HC_W-1:0] hcnt,
  output logic [VC_W-1:0] vcnt,
  output logic            active_c,
  output logic            hsync_c,
  output logic            vsync_c,
  output logic            line_end_c,
  output logic            frame_end_c
);

  localparam int unsigned DIV_W        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned V_TOT        = V_ACTIVE_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;
  localparam int unsigned H_SYNC_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
  localparam int unsigned V_SYNC_FIRST = V_ACTIVE_LINES + V_FP_LINES;
  localparam int unsigned V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC_LINES - 1;

  logic [DIV_W-1:0] div_cnt;

  assign pix_en_c    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign line_end_c  = (hcnt == HC_W'(H_TOTAL - 1));
  assign frame_end_c = line_end_c && (vcnt == VC_W'(V_TOT - 1));
  assign active_c    = (hcnt < HC_W'(H_ACTIVE)) && (vcnt < VC_W'(V_ACTIVE_LINES));
  assign hsync_c     = (hcnt >= HC_W'(H_SYNC_FIRST)) && (hcnt <= HC_W'(H_SYNC_LAST));
  assign vsync_c     = (vcnt >= VC_W'(V_SYNC_FIRST)) && (vcnt <= VC_W'(V_SYNC_LAST));

  // Clock divider: one pixel strobe every CLK_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_en_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster position; vcnt steps when the line wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en_c) begin
      if (line_end_c) begin
        hcnt <= '0;
        vcnt <= frame_end_c ? '0 : vcnt + VC_W'(1);
      end else begin
        hcnt <= hcnt + HC_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer scan-out: linear read address generation and registered VGA pin drive.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned V_ACTIVE_LINES = V_ACTIVE,
  parameter int unsigned V_FP_LINES     = V_FP,
  parameter int unsigned V_SYNC_LINES   = V_SYNC,
  parameter int unsigned V_BP_LINES     = V_BP
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] raddr,
  input  logic [8:0]  rdata,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        vga_blank_n,
  output logic        frame_start,
  output logic        in_vblank
);

  logic            pix_en_c;
  logic [HC_W-1:0] hcnt;
  logic [VC_W-1:0] vcnt;
  logic            active_c;
  logic            hsync_c;
  logic            vsync_c;
  logic            line_end_c;
  logic            frame_end_c;
  logic            last_active_c;
  logic [VC_W-1:0] vcnt_nxt_c;
  pix9_t           px_c;

  vga_timing_gen #(
    .CLK_DIV        (CLK_DIV),
    .V_ACTIVE_LINES (V_ACTIVE_LINES),
    .V_FP_LINES     (V_FP_LINES),
    .V_SYNC_LINES   (V_SYNC_LINES),
    .V_BP_LINES     (V_BP_LINES)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en_c    (pix_en_c),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active_c    (active_c),
    .hsync_c     (hsync_c),
    .vsync_c     (vsync_c),
    .line_end_c  (line_end_c),
    .frame_end_c (frame_end_c)
  );

  assign px_c          = pix9_t'(rdata);
  assign last_active_c = (hcnt == HC_W'(H_ACTIVE - 1)) && (vcnt == VC_W'(V_ACTIVE_LINES - 1));
  assign vcnt_nxt_c    = frame_end_c ? '0 : (line_end_c ? vcnt + VC_W'(1) : vcnt);

  // Read address tracks the current active pixel and parks on the next one during blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr <= '0;
    end else if (pix_en_c) begin
      if (last_active_c) begin
        raddr <= '0;
      end else if (active_c) begin
        raddr <= raddr + ADDR_W'(1);
      end
    end
  end

  // Pin stage: sync, blank and colour share one register so they stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
      in_vblank   <= 1'b0;
    end else if (pix_en_c) begin
      vga_r       <= active_c ? expand3to8(px_c.r) : '0;
      vga_g       <= active_c ? expand3to8(px_c.g) : '0;
      vga_b       <= active_c ? expand3to8(px_c.b) : '0;
      vga_hs_n    <= !hsync_c;
      vga_vs_n    <= !vsync_c;
      vga_blank_n <= active_c;
      in_vblank   <= (vcnt_nxt_c >= VC_W'(V_ACTIVE_LINES));
    end
  end

  // One-clock pulse as the raster wraps back to the top-left pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en_c && frame_end_c;
    end
  end

endmodule
